chip8_call_ret_ctrl: RTL and testbench

Sequences the Chip-8 return-address stack for CALL (2NNN) and RET (00EE) instructions on behalf of the CPU core. It accepts one subroutine request at a time and drives the stack's 2-bit WE/writedata interface. It tracks stack depth, reports overflow and underflow, and hands the CPU a PC load. It sits between the instruction decoder/PC logic and the stack block.

---
 rtl/chip8_call_ret_ctrl_if.sv | 27 ++
 rtl/chip8_call_ret_ctrl.sv | 110 +++++++++++
 tb/tb_chip8_call_ret_ctrl.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/chip8_call_ret_ctrl_if.sv
// Request/response and stack-port bundle between the CPU core, the
// CALL/RET sequencer and the return-address stack.
interface chip8_call_ret_ctrl_if;
  logic        req_valid;
  logic [1:0]  req_op;
  logic [11:0] req_target;
  logic [15:0] cur_pc;
  logic        req_ready;
  logic [1:0]  stk_we;
  logic [15:0] stk_wdata;
  logic [15:0] stk_rdata;
  logic        pc_load;
  logic [15:0] pc_next;
  logic        done;

  // CPU core together with the stack block
  modport master (
    output req_valid, req_op, req_target, cur_pc, stk_rdata,
    input  req_ready, stk_we, stk_wdata, pc_load, pc_next, done
  );

  // CALL/RET sequencer
  modport slave (
    input  req_valid, req_op, req_target, cur_pc, stk_rdata,
    output req_ready, stk_we, stk_wdata, pc_load, pc_next, done
  );
endinterface

// File: rtl/chip8_call_ret_ctrl.sv
// Chip-8 CALL/RET sequencer: drives the return-address stack, tracks depth,
// flags overflow/underflow and hands the CPU a PC load on completion.
module chip8_call_ret_ctrl #(
  parameter int DEPTH   = 16,
  parameter int DEPTH_W = 5,
  parameter int PC_INC  = 2
) (
  input  logic               cpu_clk,
  input  logic               reset,
  chip8_call_ret_ctrl_if.slave bus,
  input  logic               clr_err,
  output logic [DEPTH_W-1:0] depth,
  output logic               err_overflow,
  output logic               err_underflow
);

  typedef enum logic [2:0] {IDLE, PUSH, POP, POP_WAIT, DONE} state_t;

  localparam logic [1:0] OP_CALL = 2'b01;
  localparam logic [1:0] OP_RET  = 2'b10;

  state_t             state_q, state_d;
  logic               load_q;
  logic [15:0]        wdata_q;
  logic [15:0]        pc_next_q;
  logic [DEPTH_W-1:0] depth_q;
  logic               ovf_q, unf_q;

  logic accept, is_call, is_ret, full, empty, call_ok, ret_ok;

  always_comb begin
    accept  = bus.req_valid && (state_q == IDLE);
    is_call = (bus.req_op == OP_CALL);
    is_ret  = (bus.req_op == OP_RET);
    full    = (depth_q == DEPTH_W'(DEPTH));
    empty   = (depth_q == '0);
    call_ok = is_call && !full;
    ret_ok  = is_ret && !empty;
  end

  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (call_ok)     state_d = PUSH;
          else if (ret_ok) state_d = POP;
          else             state_d = DONE;
        end
      end
      PUSH:     state_d = DONE;
      POP:      state_d = POP_WAIT;
      POP_WAIT: state_d = DONE;
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Stack strobe is a pure decode of state, so it can never pulse elsewhere.
  always_comb begin
    bus.stk_we    = (state_q == PUSH) ? 2'b01 :
                    (state_q == POP)  ? 2'b10 : 2'b00;
    bus.req_ready = (state_q == IDLE);
    bus.done      = (state_q == DONE);
    bus.pc_load   = (state_q == DONE) && load_q;
    bus.stk_wdata = wdata_q;
    bus.pc_next   = pc_next_q;
    depth         = depth_q;
    err_overflow  = ovf_q;
    err_underflow = unf_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge cpu_clk) begin
    if (reset) begin
      state_q   <= IDLE;
      load_q    <= 1'b0;
      wdata_q   <= '0;
      pc_next_q <= '0;
      depth_q   <= '0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
    end else begin
      state_q <= state_d;

      if (accept) begin
        load_q <= call_ok || ret_ok;
        if (call_ok) begin
          wdata_q   <= bus.cur_pc + 16'(PC_INC);
          pc_next_q <= {4'b0000, bus.req_target};
        end
      end

      if (state_q == PUSH) depth_q <= depth_q + 1'b1;
      if (state_q == POP)  depth_q <= depth_q - 1'b1;
      if (state_q == POP_WAIT) pc_next_q <= bus.stk_rdata;

      // A new error wins over a clear arriving on the same edge.
      if (accept && is_call && full) ovf_q <= 1'b1;
      else if (clr_err)              ovf_q <= 1'b0;

      if (accept && is_ret && empty) unf_q <= 1'b1;
      else if (clr_err)              unf_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_chip8_call_ret_ctrl.sv
// Directed bench for chip8_call_ret_ctrl with a small behavioural stack
// attached to the stack port; outputs are sampled on the falling edge.
module tb_chip8_call_ret_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        clr_err;
  logic [4:0]  depth;
  logic        err_overflow, err_underflow;
  int          n_checks = 0;
  int          n_fail   = 0;

  chip8_call_ret_ctrl_if bus();

  chip8_call_ret_ctrl #(.DEPTH(16), .DEPTH_W(5), .PC_INC(2)) dut (
    .cpu_clk      (clk),
    .reset        (reset),
    .bus          (bus.slave),
    .clr_err      (clr_err),
    .depth        (depth),
    .err_overflow (err_overflow),
    .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  // Return-address stack: push writes, pop presents the top on stk_rdata
  // the cycle after the pop strobe.
  logic [15:0] stk_mem [16];
  logic [4:0]  sp;
  always @(posedge clk) begin
    if (reset) begin
      sp            <= '0;
      bus.stk_rdata <= '0;
    end else if (bus.stk_we == 2'b01) begin
      stk_mem[sp[3:0]] <= bus.stk_wdata;
      sp               <= sp + 5'd1;
    end else if (bus.stk_we == 2'b10) begin
      bus.stk_rdata <= stk_mem[4'(sp - 5'd1)];
      sp            <= sp - 5'd1;
    end
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [1:0] op, input logic [11:0] tgt, input logic [15:0] pc);
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_op     = op;
    bus.req_target = tgt;
    bus.cur_pc     = pc;
    check("req_ready_before_accept", 16'(bus.req_ready), 16'h1);
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_op    = 2'b00;
  endtask

  task automatic run_call(input logic [15:0] pc, input logic [11:0] tgt,
                          input bit ok, input logic [4:0] exp_depth);
    drive(2'b01, tgt, pc);
    if (ok) begin
      check("call_push_we",    16'(bus.stk_we), 16'h0001);
      check("call_push_wdata", bus.stk_wdata, pc + 16'h0002);
      check("call_push_done",  16'(bus.done), 16'h0);
      @(negedge clk);
      check("call_done",       16'(bus.done), 16'h1);
      check("call_pc_load",    16'(bus.pc_load), 16'h1);
      check("call_pc_next",    bus.pc_next, {4'h0, tgt});
      check("call_done_we",    16'(bus.stk_we), 16'h0);
    end else begin
      check("ovf_we",          16'(bus.stk_we), 16'h0);
      check("ovf_done",        16'(bus.done), 16'h1);
      check("ovf_pc_load",     16'(bus.pc_load), 16'h0);
      check("ovf_flag",        16'(err_overflow), 16'h1);
    end
    check("call_depth", 16'(depth), 16'(exp_depth));
    @(negedge clk);
    check("call_idle_ready", 16'(bus.req_ready), 16'h1);
    check("call_idle_done",  16'(bus.done), 16'h0);
  endtask

  task automatic run_ret(input bit ok, input logic [15:0] exp_pc, input logic [4:0] exp_depth);
    drive(2'b10, 12'h000, 16'h0000);
    if (ok) begin
      check("ret_pop_we",    16'(bus.stk_we), 16'h0002);
      @(negedge clk);
      check("ret_wait_we",   16'(bus.stk_we), 16'h0);
      check("ret_wait_done", 16'(bus.done), 16'h0);
      @(negedge clk);
      check("ret_done",      16'(bus.done), 16'h1);
      check("ret_pc_load",   16'(bus.pc_load), 16'h1);
      check("ret_pc_next",   bus.pc_next, exp_pc);
    end else begin
      check("unf_we",        16'(bus.stk_we), 16'h0);
      check("unf_done",      16'(bus.done), 16'h1);
      check("unf_pc_load",   16'(bus.pc_load), 16'h0);
      check("unf_flag",      16'(err_underflow), 16'h1);
    end
    check("ret_depth", 16'(depth), 16'(exp_depth));
    @(negedge clk);
    check("ret_idle_ready", 16'(bus.req_ready), 16'h1);
    check("ret_idle_we",    16'(bus.stk_we), 16'h0);
  endtask

  initial begin
    reset          = 1'b1;
    clr_err        = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_op     = 2'b00;
    bus.req_target = '0;
    bus.cur_pc     = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst_ready",   16'(bus.req_ready), 16'h1);
    check("rst_we",      16'(bus.stk_we), 16'h0);
    check("rst_wdata",   bus.stk_wdata, 16'h0);
    check("rst_pc_load", 16'(bus.pc_load), 16'h0);
    check("rst_pc_next", bus.pc_next, 16'h0);
    check("rst_done",    16'(bus.done), 16'h0);
    check("rst_depth",   16'(depth), 16'h0);
    check("rst_ovf",     16'(err_overflow), 16'h0);
    check("rst_unf",     16'(err_underflow), 16'h0);

    // Single CALL/RET pair
    run_call(16'h0200, 12'h345, 1'b1, 5'd1);
    run_ret(1'b1, 16'h0202, 5'd0);

    // No-op requests complete without touching the stack
    drive(2'b00, 12'hABC, 16'h0800);
    check("nop00_we",      16'(bus.stk_we), 16'h0);
    check("nop00_done",    16'(bus.done), 16'h1);
    check("nop00_pc_load", 16'(bus.pc_load), 16'h0);
    @(negedge clk);
    drive(2'b11, 12'hABC, 16'h0800);
    check("nop11_we",      16'(bus.stk_we), 16'h0);
    check("nop11_done",    16'(bus.done), 16'h1);
    check("nop11_pc_load", 16'(bus.pc_load), 16'h0);
    check("nop11_depth",   16'(depth), 16'h0);
    check("nop11_unf",     16'(err_underflow), 16'h0);
    @(negedge clk);

    // Nested calls unwind in reverse order
    run_call(16'h0200, 12'h300, 1'b1, 5'd1);
    run_call(16'h0300, 12'h400, 1'b1, 5'd2);
    run_call(16'h0400, 12'h500, 1'b1, 5'd3);
    run_ret(1'b1, 16'h0402, 5'd2);
    run_ret(1'b1, 16'h0302, 5'd1);
    run_ret(1'b1, 16'h0202, 5'd0);

    // Underflow with clr_err on the same edge: the set wins, then clears
    clr_err = 1'b1;
    run_ret(1'b0, 16'h0000, 5'd0);
    check("unf_cleared", 16'(err_underflow), 16'h0);
    clr_err = 1'b0;

    // Underflow flag survives a later successful CALL
    run_ret(1'b0, 16'h0000, 5'd0);
    run_call(16'h0FFE, 12'h123, 1'b1, 5'd1);
    check("unf_sticky", 16'(err_underflow), 16'h1);
    run_ret(1'b1, 16'h1000, 5'd0);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    check("unf_clr", 16'(err_underflow), 16'h0);

    // Fill the stack, then overflow
    for (int i = 0; i < 16; i++)
      run_call(16'h0100 + 16'(i) * 16'h0010, 12'h200 + 12'(i), 1'b1, 5'(i + 1));
    run_call(16'h0E00, 12'h777, 1'b0, 5'd16);
    check("ovf_pc_next_kept", bus.pc_next, 16'h020F);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    check("ovf_clr", 16'(err_overflow), 16'h0);

    // Unwind all sixteen
    for (int i = 15; i >= 0; i--)
      run_ret(1'b1, 16'h0102 + 16'(i) * 16'h0010, 5'(i));

    // Reset during POP_WAIT aborts the return
    run_call(16'h0600, 12'h654, 1'b1, 5'd1);
    drive(2'b10, 12'h000, 16'h0000);
    check("abort_pop_we", 16'(bus.stk_we), 16'h0002);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort_done",    16'(bus.done), 16'h0);
    check("abort_pc_load", 16'(bus.pc_load), 16'h0);
    check("abort_we",      16'(bus.stk_we), 16'h0);
    check("abort_depth",   16'(depth), 16'h0);
    reset = 1'b0;
    @(negedge clk);
    check("abort_ready",   16'(bus.req_ready), 16'h1);
    check("abort_done2",   16'(bus.done), 16'h0);
    check("abort_pc_next", bus.pc_next, 16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
